// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the hazard sequencer and the pipeline datapath.
// The slave side is the sequencer; the master side is the pipeline/CPU top.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
) ();
   logic             start_i;
   logic             ID_EX_MemRead_i;
   logic [4:0]       ID_EX_inst20_16_i;
   logic [4:0]       IF_ID_inst25_21_i;
   logic [4:0]       IF_ID_inst20_16_i;
   logic             branch_taken_i;
   logic             jump_i;
   logic             mem_req_i;
   logic             mem_ack_i;
   logic             PC_write_o;
   logic             IF_ID_write_o;
   logic             IF_ID_flush_o;
   logic             ID_EX_bubble_o;
   logic             pipe_stall_o;
   logic             err_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport slave (
      input  start_i, ID_EX_MemRead_i, ID_EX_inst20_16_i, IF_ID_inst25_21_i,
             IF_ID_inst20_16_i, branch_taken_i, jump_i, mem_req_i, mem_ack_i,
      output PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
             pipe_stall_o, err_o, stall_cnt_o, flush_cnt_o
   );

   modport master (
      output start_i, ID_EX_MemRead_i, ID_EX_inst20_16_i, IF_ID_inst25_21_i,
             IF_ID_inst20_16_i, branch_taken_i, jump_i, mem_req_i, mem_ack_i,
      input  PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
             pipe_stall_o, err_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use bubbles, memory freeze, branch flush.
// Optional performance counters are enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   pipe_hazard_ctrl_if.slave   bus
);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_MEM_WAIT, S_ERROR} state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              load_use;
   logic              pc_write;
   logic              if_id_write;
   logic              if_id_flush;
   logic              id_ex_bubble;
   logic              pipe_stall;

   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_stall   = 1'b1;
      load_use     = bus.ID_EX_MemRead_i && (bus.ID_EX_inst20_16_i != 5'd0) &&
                     ((bus.ID_EX_inst20_16_i == bus.IF_ID_inst25_21_i) ||
                      (bus.ID_EX_inst20_16_i == bus.IF_ID_inst20_16_i));
      case (state_q)
         S_IDLE: begin
            if (bus.start_i) state_d = S_RUN;
         end
         S_RUN: begin
            if (bus.mem_req_i && !bus.mem_ack_i) begin
               state_d = S_MEM_WAIT;
               wait_d  = WAIT_W'(1);
            end else if (load_use) begin
               // Branch/jump flush is held off so the stalled instruction is not lost.
               pipe_stall   = 1'b0;
               id_ex_bubble = 1'b1;
            end else begin
               pipe_stall  = 1'b0;
               pc_write    = 1'b1;
               if_id_write = 1'b1;
               if_id_flush = bus.branch_taken_i || bus.jump_i;
            end
         end
         S_MEM_WAIT: begin
            if (bus.mem_ack_i) begin
               pipe_stall = 1'b0;
               state_d    = S_RUN;
            end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
               state_d = S_ERROR;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: begin
            state_d = S_ERROR;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   assign bus.PC_write_o     = pc_write;
   assign bus.IF_ID_write_o  = if_id_write;
   assign bus.IF_ID_flush_o  = if_id_flush;
   assign bus.ID_EX_bubble_o = id_ex_bubble;
   assign bus.pipe_stall_o   = pipe_stall;
   assign bus.err_o          = (state_q == S_ERROR);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Both counters stick at all-ones rather than wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (((state_q == S_RUN) || (state_q == S_MEM_WAIT)) && !pc_write &&
          (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (if_id_flush && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.stall_cnt_o = stall_cnt_q;
   assign bus.flush_cnt_o = flush_cnt_q;
`else
   assign bus.stall_cnt_o = '0;
   assign bus.flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios followed by random traffic,
// checked against a cycle-level reference model of the sequencer rules.
module tb_pipe_hazard_ctrl;
   localparam int MT = 16;
   localparam int CW = 4;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();
   pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct packed {
      logic          pc_w;
      logic          ifid_w;
      logic          flush;
      logic          bubble;
      logic          stall;
      logic          err;
      logic [CW-1:0] scnt;
      logic [CW-1:0] fcnt;
   } exp_t;

   exp_t expq[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Reference model: mode 0=idle 1=run 2=waiting on memory 3=error
   int m_mode   = 0;
   int m_waited = 0;
   int m_scnt   = 0;
   int m_fcnt   = 0;
   bit m_known  = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic model_and_push(input bit r, st, mr, input logic [4:0] rtex, rs, rt,
                                 input bit br, jp, rq, ak);
      exp_t e;
      int   nm;
      int   sat;
      bit   hazard;
      sat    = (1 << CW) - 1;
      hazard = mr && (rtex != 0) && ((rtex == rs) || (rtex == rt));
      nm     = m_mode;
      e      = '0;
      e.stall = 1'b1;
      e.err   = (m_mode == 3);
      if (m_mode == 0) begin
         if (st) nm = 1;
      end else if (m_mode == 1) begin
         if (rq && !ak) begin
            m_waited = 1;
            nm = 2;
         end else if (hazard) begin
            e.bubble = 1'b1;
            e.stall  = 1'b0;
         end else begin
            e.pc_w   = 1'b1;
            e.ifid_w = 1'b1;
            e.stall  = 1'b0;
            e.flush  = br || jp;
         end
      end else if (m_mode == 2) begin
         if (ak) begin
            e.stall = 1'b0;
            nm = 1;
         end else begin
            m_waited++;
            if (m_waited == MT) nm = 3;
         end
      end
      e.scnt = PERF ? CW'(m_scnt) : '0;
      e.fcnt = PERF ? CW'(m_fcnt) : '0;
      if ((m_mode == 1 || m_mode == 2) && !e.pc_w && m_scnt < sat) m_scnt++;
      if (e.flush && m_fcnt < sat) m_fcnt++;
      if (m_known) expq.push_back(e);
      if (!r) begin
         m_mode  = 0;
         m_scnt  = 0;
         m_fcnt  = 0;
         m_known = 1'b1;
      end else begin
         m_mode = nm;
      end
   endtask

   task automatic drive(input bit r, st, mr, input logic [4:0] rtex, rs, rt,
                        input bit br, jp, rq, ak);
      rst                   = r;
      bus.start_i           = st;
      bus.ID_EX_MemRead_i   = mr;
      bus.ID_EX_inst20_16_i = rtex;
      bus.IF_ID_inst25_21_i = rs;
      bus.IF_ID_inst20_16_i = rt;
      bus.branch_taken_i    = br;
      bus.jump_i            = jp;
      bus.mem_req_i         = rq;
      bus.mem_ack_i         = ak;
      model_and_push(r, st, mr, rtex, rs, rt, br, jp, rq, ak);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         chk("PC_write",     32'(bus.PC_write_o),     32'(e.pc_w));
         chk("IF_ID_write",  32'(bus.IF_ID_write_o),  32'(e.ifid_w));
         chk("IF_ID_flush",  32'(bus.IF_ID_flush_o),  32'(e.flush));
         chk("ID_EX_bubble", 32'(bus.ID_EX_bubble_o), 32'(e.bubble));
         chk("pipe_stall",   32'(bus.pipe_stall_o),   32'(e.stall));
         chk("err",          32'(bus.err_o),          32'(e.err));
         chk("stall_cnt",    32'(bus.stall_cnt_o),    32'(e.scnt));
         chk("flush_cnt",    32'(bus.flush_cnt_o),    32'(e.fcnt));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset, idle, then start
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // load-use on Rs, then Rt_EX = 0
      drive(1, 0, 1, 5, 5, 1, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      // load-use with branch suppresses flush; then plain branch and jump
      drive(1, 0, 1, 7, 2, 7, 1, 0, 0, 0);
      drive(1, 0, 0, 7, 2, 7, 1, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      // request and ack in same cycle: no stall
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      // memory access acked after 3 cycles
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // memory timeout into ERROR, then reset out of it
      for (int i = 0; i < MT + 3; i++) drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      // flush counter saturation
      for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      // random traffic
      for (int i = 0; i < 2000; i++) begin
         drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 3));
      end
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      chk("queue_drain", 32'(expq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
